// File: rtl/sample_arb_pkg.sv
// Shared types for the wave-sample BRAM read arbiter: requester ids and the
// in-flight read tag that follows each BRAM access.
package sample_arb_pkg;

  localparam int NUM_OSC       = 4;
  localparam int SAMPLE_W      = 16;
  localparam int WW_W          = 15;
  localparam int READ_LAT      = 2;
  localparam int VIZ_WAIT_MAX  = 8;

  // Oscillators take ids 0..NUM_OSC-1; the viz requester sits just above them.
  localparam int ID_W = $clog2(NUM_OSC + 1);
  typedef logic [ID_W-1:0] req_id_t;
  localparam req_id_t VIZ_ID = req_id_t'(NUM_OSC);

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/sample_read_arbiter_rr_grant.sv
// Round-robin pick of one pending requester, searching upward from ptr.
// Pure combinational; grants nothing while enable is low.
module rr_grant #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic             any_grant
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        idx = PTR_W'((int'(ptr) + k) % N);
        if (!any_grant && pending[idx]) begin
          grant[idx] = 1'b1;
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sample_read_arbiter.sv
// Shares the wave BRAM read port between N oscillators (round-robin) and a low-priority viz port.
// Latency: req -> valid pulse in 2+READ_LATENCY cycles; 1 read/cycle; load_hold_in stalls new grants.
// Optional SAMPLE_ARB_VIZ_GUARD_EN bounds viz starvation to VIZ_MAX_WAIT eligible cycles.
module sample_read_arbiter
  import sample_arb_pkg::*;
#(
  parameter int NUM_OSCILLATORS = NUM_OSC,
  parameter int SAMPLE_WIDTH    = SAMPLE_W,
  parameter int WW_WIDTH        = WW_W,
  parameter int READ_LATENCY    = READ_LAT,
  parameter int VIZ_MAX_WAIT    = VIZ_WAIT_MAX
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic [NUM_OSCILLATORS-1:0]                   osc_req_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     osc_index_in,
  output logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_data_out,
  output logic [NUM_OSCILLATORS-1:0]                   osc_valid_out,
  input  logic                                         viz_req_in,
  input  logic [WW_WIDTH-1:0]                          viz_index_in,
  output logic [SAMPLE_WIDTH-1:0]                      viz_data_out,
  output logic                                         viz_valid_out,
  input  logic                                         load_hold_in,
  output logic                                         bram_en_out,
  output logic [WW_WIDTH-1:0]                          bram_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]                      bram_data_in
);

  localparam int PTR_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;

  logic [NUM_OSCILLATORS:0]               pend_q;
  logic [NUM_OSCILLATORS:0][WW_WIDTH-1:0] index_q;
  logic [PTR_W-1:0]                       rr_ptr_q;
  logic [PTR_W-1:0]                       rr_ptr_nxt;
  tag_t [READ_LATENCY-1:0]                tag_q;
  tag_t                                   tag_exit;

  logic [NUM_OSCILLATORS-1:0] osc_grant;
  logic                       osc_any;
  logic                       viz_grant;
  logic                       viz_force;
  logic                       grant_any;
  req_id_t                    grant_id;
  logic [WW_WIDTH-1:0]        grant_addr;
  logic [NUM_OSCILLATORS:0]   req_all;
  logic [NUM_OSCILLATORS:0]   grant_vec;

  assign req_all   = {viz_req_in, osc_req_in};
  assign grant_vec = {viz_grant, osc_grant};
  assign tag_exit  = tag_q[READ_LATENCY-1];

`ifdef SAMPLE_ARB_VIZ_GUARD_EN
  localparam int WAIT_W = $clog2(VIZ_MAX_WAIT + 1);
  logic [WAIT_W-1:0] viz_wait_q;

  assign viz_force = pend_q[NUM_OSCILLATORS] && (viz_wait_q >= WAIT_W'(VIZ_MAX_WAIT));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      viz_wait_q <= '0;
    end else if (viz_grant) begin
      viz_wait_q <= '0;
    end else if (pend_q[NUM_OSCILLATORS] && !load_hold_in && !viz_force) begin
      viz_wait_q <= viz_wait_q + 1'b1;
    end
  end
`else
  // Strict lowest priority: the wait bound never forces a viz grant.
  assign viz_force = (VIZ_MAX_WAIT < 0);
`endif

  rr_grant #(
    .N     (NUM_OSCILLATORS),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .pending   (pend_q[NUM_OSCILLATORS-1:0]),
    .ptr       (rr_ptr_q),
    .enable    (!load_hold_in && !viz_force),
    .grant     (osc_grant),
    .any_grant (osc_any)
  );

  assign viz_grant = !load_hold_in && pend_q[NUM_OSCILLATORS] && (viz_force || !osc_any);
  assign grant_any = osc_any || viz_grant;

  always_comb begin
    grant_id   = VIZ_ID;
    grant_addr = index_q[NUM_OSCILLATORS];
    rr_ptr_nxt = rr_ptr_q;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      if (osc_grant[i]) begin
        grant_id   = req_id_t'(i);
        grant_addr = index_q[i];
        rr_ptr_nxt = PTR_W'((i + 1) % NUM_OSCILLATORS);
      end
    end
  end

  // A same-cycle grant consumes the old index; a new req re-arms pending.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_q   <= '0;
      index_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      pend_q <= (pend_q & ~grant_vec) | req_all;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        if (osc_req_in[i]) index_q[i] <= osc_index_in[i];
      end
      if (viz_req_in) index_q[NUM_OSCILLATORS] <= viz_index_in;
      if (osc_any) rr_ptr_q <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      tag_q         <= '0;
    end else begin
      bram_en_out <= grant_any;
      if (grant_any) bram_addr_out <= grant_addr;
      tag_q[0].valid <= grant_any;
      tag_q[0].id    <= grant_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Returning data lands only in the tagged requester's register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      osc_data_out  <= '0;
      osc_valid_out <= '0;
      viz_data_out  <= '0;
      viz_valid_out <= 1'b0;
    end else begin
      osc_valid_out <= '0;
      viz_valid_out <= 1'b0;
      if (tag_exit.valid) begin
        if (tag_exit.id == VIZ_ID) begin
          viz_data_out  <= bram_data_in;
          viz_valid_out <= 1'b1;
        end
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          if (tag_exit.id == req_id_t'(i)) begin
            osc_data_out[i]  <= bram_data_in;
            osc_valid_out[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
